// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial unsigned subtractor controller.
// Computes diff = a - b (mod 2^WIDTH) one bit per clock, LSB first, through a
// single full-subtractor cell. A start/done handshake sequences each operation;
// diff and borrow_out are held until the next operation completes.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             d_bit;
  logic             br_next;

  // Full-subtractor cell operating on the current LSBs and the stored borrow.
  always_comb begin
    d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
    br_next = (~sa_q[0] & sb_q[0]) | ((~sa_q[0] | sb_q[0]) & br_q);
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every variable gets a default here so no path can leave one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      // DONE accepts a new request exactly like IDLE, giving back-to-back ops.
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          sr_d    = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = {d_bit, sr_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last bit: publish the completed word and final borrow together.
          diff_d   = {d_bit, sr_q[WIDTH-1:1]};
          borrow_d = br_next;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller that computes an unsigned WIDTH-bit A − B using one full-subtractor cell, one bit per clock, LSB first. It owns the operand shift registers, the borrow flip-flop, the bit counter and a start/done handshake. It is the sequencing layer that lets the single-bit subtractor datapath serve word-wide operands.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset; sampled on rising clk.
- start  input  1  request; accepted only on a rising edge where busy=0.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; result valid.
- diff  output  WIDTH  A − B mod 2^WIDTH; registered.
- borrow_out  output  1  final borrow; 1 means A < B (unsigned).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1:
  - load sa←a, sb←b;
  - clear the borrow register br and the internal result shift register sr;
  - cnt←0; go to RUN.
- RUN (busy=1), per edge:
  - d = sa[0]^sb[0]^br;
  - br ← (~sa[0]&sb[0]) | ((~sa[0]|sb[0])&br);
  - sr ← {d, sr[WIDTH-1:1]};
  - sa, sb shift right by 1; cnt ← cnt+1.
- End of RUN: on the edge processing bit WIDTH−1 (cnt=WIDTH−1):
  - diff ← {d, sr[WIDTH-1:1]};
  - borrow_out ← the new borrow;
  - go to DONE.
- DONE: done=1, busy=0 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back); the next state is RUN.
  - Otherwise the next state is IDLE.
- start while busy=1 is ignored. It is not queued, and a/b are not re-sampled.
- diff and borrow_out change only at completion. They hold the last result through IDLE and through the entire next operation.
- cnt width is clog2(WIDTH). It must not wrap before completion.
- Reset:
  - rst=1 forces state=IDLE and busy=0, done=0, diff=0, borrow_out=0.
  - Internal registers sa, sb, sr, br and cnt are also cleared.
  - rst has priority over start.
  - rst during RUN aborts the operation: no done pulse, and the result is discarded.

## Timing
- Call the accepting edge E0. Output values below are those seen after each edge.
- After E0: busy=1.
- Edges E1..E_WIDTH process bits 0..WIDTH−1.
- After E_WIDTH: busy=0, done=1, and diff/borrow_out are valid.
- After E_WIDTH+1: done=0, unless a back-to-back accept at E_WIDTH+1 started a new op, in which case busy=1 again.
- Latency from start to done: WIDTH+1 edges.
- Throughput: one result per WIDTH+1 cycles.
- done and busy are never high in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Basic (WIDTH=8): a=0x5A, b=0x23, one-cycle start.
  - Required: done exactly 9 edges after accept; diff=0x37, borrow_out=0.
  - Required: busy high for the 8 cycles before done.
- Underflow and equal operands:
  - a=0x00, b=0x01 → diff=0xFF, borrow_out=1.
  - a=0xC4, b=0xC4 → diff=0x00, borrow_out=0.
  - a=0x80, b=0xFF → diff=0x81, borrow_out=1.
- Ignored start: accept a=0x10, b=0x01.
  - At edge E3, pulse start with a=0xFF, b=0x00.
  - Required: single done at E8 with diff=0x0F; no extra done follows.
- Back-to-back: during the done cycle of op1 (0x05−0x03=0x02), assert start with a=0x03, b=0x05.
  - Required: op2 done 9 edges later with diff=0xFE, borrow_out=1.
  - Required: diff holds 0x02 until then.
- Reset mid-operation: accept, then rst=1 at E4 for one cycle.
  - Required: after that edge, busy=0, done=0, diff=0, borrow_out=0.
  - Required: no done pulse until a new start; the next op (0x09−0x04) yields 0x05.
- Parameter sweep: WIDTH=4 and WIDTH=16, with 1000 random operand pairs each, compared against a reference model (a−b) mod 2^WIDTH and borrow=(a<b).
  - Required: done at WIDTH+1 edges after accept.
